// File: rtl/pipelined_dual_port_ram.sv
// Dual-port RAM with byte-enable writes, self-zeroing init and an optional output register.
// Ports: clk/rst, write (we, be, add_w, data_w), read (re, add_r, data_r, valid_r), ready.
module pipelined_dual_port_ram #(
  parameter int data_width    = 16,
  parameter int address_width = 7,
  parameter int read_mode     = 0,
  parameter int out_reg       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [data_width/8-1:0]    be,
  input  logic [address_width-1:0]   add_w,
  input  logic [data_width-1:0]      data_w,
  input  logic                       re,
  input  logic [address_width-1:0]   add_r,
  output logic [data_width-1:0]      data_r,
  output logic                       valid_r,
  output logic                       ready
);

  localparam int NB    = data_width / 8;
  localparam int DEPTH = 1 << address_width;
  localparam logic [address_width-1:0] ONE  = 1;
  localparam logic [address_width-1:0] LAST = '1;

  typedef enum logic {INIT, READY} state_e;

  state_e                     state_q, state_d;
  logic [address_width-1:0]   cnt_q, cnt_d;
  logic [data_width-1:0]      mem [DEPTH];

  logic                       wr_en;
  logic [address_width-1:0]   wr_addr;
  logic [NB-1:0]              wr_be;
  logic [data_width-1:0]      wr_data;
  logic [data_width-1:0]      rd_word;
  logic                       rd_acc;

  logic [data_width-1:0]      s1_data_q, s1_data_d;
  logic                       s1_valid_q, s1_valid_d;

  assign ready  = (state_q == READY);
  assign rd_acc = ready && re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == LAST) begin
        state_d = READY;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Init sweep and user writes share the single write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = add_w;
    wr_be   = be;
    wr_data = data_w;
    unique case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_be   = '1;
        wr_data = '0;
      end
      READY: wr_en = we;
      default: wr_en = 1'b0;
    endcase
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first: forward enabled bytes of a colliding write.
  always_comb begin
    rd_word = mem[add_r];
    if (read_mode == 1 && ready && we && add_r == add_w) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) rd_word[8*i +: 8] = data_w[8*i +: 8];
      end
    end
  end

  always_comb begin
    s1_valid_d = rd_acc;
    s1_data_d  = rd_acc ? rd_word : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  generate
    if (out_reg == 1) begin : g_out
      logic [data_width-1:0] s2_data_q, s2_data_d;
      logic                  s2_valid_q, s2_valid_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
        end else begin
          s2_data_q  <= s2_data_d;
          s2_valid_q <= s2_valid_d;
        end
      end

      assign data_r  = s2_data_q;
      assign valid_r = s2_valid_q;
    end else begin : g_noout
      assign data_r  = s1_data_q;
      assign valid_r = s1_valid_q;
    end
  endgenerate

endmodule

// File: doc/pipelined_dual_port_ram.md
PIPELINED_DUAL_PORT_RAM -- requirements
Module: pipelined_dual_port_ram

Interface
REQ-001 SHALL have parameter data_width, default 16: width of a memory word; integer multiple of 8.
REQ-002 SHALL have parameter address_width, default 7: address bits; depth = 2**address_width words.
REQ-003 SHALL have parameter read_mode, default 0: 0 = read-first (old data on collision), 1 = write-first (new data on collision).
REQ-004 SHALL have parameter out_reg, default 0: 0 = 1-cycle read latency, 1 = extra output register, 2-cycle latency.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port we, input, 1: write request.
REQ-008 SHALL have port be, input, data_width/8: byte enables for the write; bit i covers data_w[8i+7:8i].
REQ-009 SHALL have port add_w, input, address_width: write address.
REQ-010 SHALL have port data_w, input, data_width: write data.
REQ-011 SHALL have port re, input, 1: read request.
REQ-012 SHALL have port add_r, input, address_width: read address.
REQ-013 SHALL have port data_r, output, data_width: read data.
REQ-014 SHALL have port valid_r, output, 1: data_r holds the result of a read accepted out_reg+1 edges earlier.
REQ-015 SHALL have port ready, output, 1: high when initialisation is done and requests are accepted.

Function
REQ-016 SHALL implement a two-state FSM: INIT and READY; a rising edge with rst=1 enters INIT with init counter = 0.
REQ-017 In INIT, each edge SHALL write all-zero to memory[counter] and increment the counter; the edge at counter = depth-1 SHALL write that word and enter READY.
REQ-018 ready SHALL be 0 in INIT and 1 in READY; it rises exactly depth edges after the last edge with rst=1.
REQ-019 While ready=0, we and re SHALL be ignored: no user write, valid_r=0.
REQ-020 In READY, a write SHALL occur at an edge with we=1, updating only the bytes of memory[add_w] whose be bit is 1; we=1 with be=0 leaves memory unchanged.
REQ-021 In READY, a read SHALL be accepted at an edge with re=1; with out_reg=0, data_r and valid_r=1 SHALL update at that same edge.
REQ-022 With out_reg=1, the read result SHALL pass through one more register: data_r and valid_r=1 appear one edge later; back-to-back reads SHALL sustain one result per cycle.
REQ-023 valid_r SHALL be 0 on every edge with no matching accepted read; data_r SHALL hold its last value when no result is produced.
REQ-024 Collision (re=we=1, add_r=add_w, same edge): read_mode=0 SHALL return the pre-write word; read_mode=1 SHALL return the pre-write word with enabled bytes replaced by data_w.
REQ-025 Reads and writes to different addresses in the same cycle SHALL be independent.
REQ-026 Address arithmetic in the init counter SHALL be address_width bits; no wrap beyond depth-1 during INIT.

Reset
REQ-027 rst=1 at an edge SHALL set data_r=0, valid_r=0, ready=0, any out_reg pipeline stage (data and valid) to 0, state=INIT, counter=0.
REQ-028 rst asserted during INIT SHALL restart initialisation from address 0; rst asserted in READY SHALL discard in-flight reads (no valid_r after reset).
REQ-029 Memory contents SHALL be all-zero when ready first rises after any reset.

Verification (data_width=16, address_width=4, depth 16)
REQ-030 rst=1 for 2 edges, then 0 -> ready=0 for 16 edges, ready=1 at 16th edge; reads of addresses 0..15 return 0x0000.
REQ-031 out_reg=0: write 0xBEEF to addr 3 (be=11), then re=1 add_r=3 -> data_r=0xBEEF, valid_r=1 at that edge; out_reg=1 -> one edge later.
REQ-032 Addr 5 holds 0x1234; write 0xABCD with be=01 -> subsequent read returns 0x12CD.
REQ-033 Addr 7 holds 0x1111; same edge we=1 be=11 data_w=0x2222, re=1, both addresses 7 -> read_mode=0 returns 0x1111, read_mode=1 returns 0x2222; later read returns 0x2222.
REQ-034 rst=1 at 8th INIT edge -> ready stays 0 for 16 further edges; we=1 during INIT to addr 2 with 0xFFFF -> addr 2 reads 0x0000 after ready.
REQ-035 out_reg=1, re=1 at edge N, rst=1 at edge N+1 -> valid_r=0 and data_r=0 after edge N+1; no valid_r afterwards.
